// File: rtl/cfg_scan_chain_pkg.sv
// Shared types and helpers for the configuration scan chain.
package cfg_scan_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2,
        ST_OVER  = 2'd3
    } scan_state_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cfg_scan_chain_shadow_reg.sv
// Committed configuration word: load-enable register with async reset.
module cfg_shadow_reg #(
    parameter int unsigned SIZE = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [SIZE-1:0] d_i,
    output logic [SIZE-1:0] q_o
);

    logic [SIZE-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/cfg_scan_chain.sv
// Serial configuration chain: shift register, frame-length FSM and a
// shadow register that only takes frames of exactly SIZE bits.
module cfg_scan_chain
    import cfg_scan_chain_pkg::*;
#(
    parameter  int unsigned SIZE  = 32,
    localparam int unsigned CNT_W = clog2(SIZE + 1)
) (
    input  logic             scan_clk,
    input  logic             rst,
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out,
    input  logic             update,
    input  logic             capture,
    input  logic [SIZE-1:0]  cap_data,
    output logic [SIZE-1:0]  out,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             upd_ok,
    output logic             upd_err
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SIZE);

    if (SIZE < 2 || SIZE > 1024) begin : g_bad_size
        $error("cfg_scan_chain: SIZE must be in 2..1024");
    end

    scan_state_e      state_q;
    logic [SIZE-1:0]  sr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             upd_ok_q;
    logic             upd_err_q;
    logic             commit_c;

    assign cnt_inc  = cnt_q + CNT_W'(1);
    // Capture outranks update, so a simultaneous capture suppresses the commit.
    assign commit_c = update && !capture && (state_q == ST_FULL);

    always_ff @(posedge scan_clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            upd_ok_q  <= 1'b0;
            upd_err_q <= 1'b0;
        end else begin
            upd_ok_q  <= 1'b0;
            upd_err_q <= 1'b0;
            if (capture) begin
                sr_q    <= cap_data;
                cnt_q   <= '0;
                state_q <= ST_IDLE;
            end else if (update) begin
                // Judged on the pre-shift state; any concurrent shift is dropped.
                upd_ok_q  <= (state_q == ST_FULL);
                upd_err_q <= (state_q != ST_FULL);
                cnt_q     <= '0;
                state_q   <= ST_IDLE;
            end else if (scan_en) begin
                sr_q <= {sr_q[SIZE-2:0], scan_in};
                unique case (state_q)
                    ST_IDLE, ST_SHIFT: begin
                        cnt_q   <= cnt_inc;
                        state_q <= (cnt_inc == CNT_FULL) ? ST_FULL : ST_SHIFT;
                    end
                    ST_FULL: begin
                        cnt_q   <= CNT_FULL;
                        state_q <= ST_OVER;
                    end
                    ST_OVER: begin
                        cnt_q   <= CNT_FULL;
                        state_q <= ST_OVER;
                    end
                    default: begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    cfg_shadow_reg #(
        .SIZE (SIZE)
    ) u_shadow (
        .clk_i  (scan_clk),
        .rst_i  (rst),
        .load_i (commit_c),
        .d_i    (sr_q),
        .q_o    (out)
    );

    assign scan_out = sr_q[SIZE-1];
    assign bit_cnt  = cnt_q;
    assign upd_ok   = upd_ok_q;
    assign upd_err  = upd_err_q;

endmodule

// File: doc/cfg_scan_chain.md
CFG_SCAN_CHAIN -- requirements
Module: cfg_scan_chain

Interface
REQ-001 SHALL have parameter SIZE, default 32, chain length in bits; legal range 2..1024.
REQ-002 SHALL have localparam CNT_W = clog2(SIZE+1), the bit-counter width.
REQ-003 SHALL have port scan_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-high.
REQ-005 SHALL have port scan_en  input  1  shift enable; one bit shifted per cycle while high.
REQ-006 SHALL have port scan_in  input  1  serial data in.
REQ-007 SHALL have port scan_out  output  1  serial data out, equal to shift register bit SIZE-1.
REQ-008 SHALL have port update  input  1  single-cycle request to commit the shift register to the shadow register.
REQ-009 SHALL have port capture  input  1  single-cycle request to parallel-load cap_data into the shift register for readback.
REQ-010 SHALL have port cap_data  input  SIZE  readback data from the fabric.
REQ-011 SHALL have port out  output  SIZE  shadow (committed) configuration word.
REQ-012 SHALL have port bit_cnt  output  CNT_W  bits shifted since the last frame start, saturating at SIZE.
REQ-013 SHALL have port upd_ok  output  1  one-cycle pulse: a commit was accepted.
REQ-014 SHALL have port upd_err  output  1  one-cycle pulse: an update was rejected.

Function
REQ-015 SHALL hold an SIZE-bit shift register; on each scan_en cycle it SHALL load {sr[SIZE-2:0], scan_in}.
REQ-016 SHALL drive out only from the shadow register; out SHALL NOT change during shifting.
REQ-017 SHALL implement FSM states IDLE (cnt=0), SHIFT (0<cnt<SIZE), FULL (cnt=SIZE) and OVER (more than SIZE bits shifted).
REQ-018 FSM transitions on scan_en: IDLE->SHIFT (or ->FULL when SIZE reached); SHIFT->FULL on the SIZE-th bit; FULL->OVER on the next bit; OVER stays OVER.
REQ-019 bit_cnt SHALL increment per shifted bit and saturate at SIZE; in OVER it SHALL read SIZE.
REQ-020 An update in FULL SHALL set shadow <= shift register, pulse upd_ok the following cycle, clear cnt and enter IDLE.
REQ-021 An update in IDLE, SHIFT or OVER SHALL leave shadow unchanged, pulse upd_err the following cycle, clear cnt and enter IDLE.
REQ-022 The shift register contents SHALL NOT be cleared by an update.
REQ-023 capture SHALL load cap_data into the shift register, clear cnt and enter IDLE; scan_out SHALL show cap_data[SIZE-1] the next cycle.
REQ-024 Priority for simultaneous requests SHALL be: capture > update > scan_en.
REQ-025 When update and scan_en are both high, update SHALL evaluate the pre-shift state and contents, and the shift SHALL be dropped.
REQ-026 When capture is high together with any other request, only the capture SHALL take effect; no pulse SHALL be generated.
REQ-027 upd_ok and upd_err SHALL be registered, mutually exclusive, and exactly one cycle wide.
REQ-028 Latency: a shifted bit SHALL appear at scan_out SIZE cycles after entry; a commit SHALL be visible on out 1 cycle after the update edge.

Reset
REQ-029 rst high SHALL immediately clear the shift register, shadow (out=0), bit_cnt=0, upd_ok=0 and upd_err=0, and set the FSM to IDLE, regardless of clock.
REQ-030 A reset asserted mid-frame SHALL abort the frame; no pending pulse SHALL survive reset.
REQ-031 The first clock edge after rst deasserts SHALL be treated as a normal cycle.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE, SHIFT, FULL, OVER) and a clog2 constant function.
REQ-033 The shadow register SHALL be a sub-module, cfg_shadow_reg (SIZE-wide load-enable register with async reset); the FSM and shift path SHALL stay in the top.

Verification
REQ-034 SIZE=8, reset, shift 8'hA5 MSB-first, then update -> out=8'hA5, upd_ok one pulse, bit_cnt=0.
REQ-035 SIZE=8, shift 5 bits, then update -> upd_err one pulse, out unchanged (0), FSM IDLE.
REQ-036 SIZE=8, shift 10 bits, then update -> upd_err, bit_cnt read 8 before the update; out unchanged.
REQ-037 cap_data=8'h3C with capture, then 8 shift cycles -> scan_out sequence 0,0,1,1,1,1,0,0.
REQ-038 update+scan_en in FULL -> commit accepted with the pre-shift word; capture+update together -> no pulse, shift register=cap_data.
REQ-039 rst asserted at bit 4 of a frame between clock edges -> all outputs 0 immediately; a subsequent full 8-bit frame commits correctly.
